// File: rtl/bldc_hall_pkg.sv
// Shared Hall-sensor code definitions: illegal codes, commutation sequence helpers.
// Pure combinational helpers, no state.
package bldc_hall_pkg;

    localparam logic [2:0] HALL_ILLEGAL_0 = 3'b000;
    localparam logic [2:0] HALL_ILLEGAL_7 = 3'b111;

    function automatic logic is_valid(input logic [2:0] code);
        return (code != HALL_ILLEGAL_0) && (code != HALL_ILLEGAL_7);
    endfunction

    // Forward rotation {A,B,C}: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101
    function automatic logic [2:0] next_fwd(input logic [2:0] code);
        case (code)
            3'b101:  next_fwd = 3'b100;
            3'b100:  next_fwd = 3'b110;
            3'b110:  next_fwd = 3'b010;
            3'b010:  next_fwd = 3'b011;
            3'b011:  next_fwd = 3'b001;
            3'b001:  next_fwd = 3'b101;
            default: next_fwd = code;
        endcase
    endfunction

    function automatic logic [2:0] next_rev(input logic [2:0] code);
        case (code)
            3'b100:  next_rev = 3'b101;
            3'b110:  next_rev = 3'b100;
            3'b010:  next_rev = 3'b110;
            3'b011:  next_rev = 3'b010;
            3'b001:  next_rev = 3'b011;
            3'b101:  next_rev = 3'b001;
            default: next_rev = code;
        endcase
    endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser plus stability counter; accepts a code held FILT_LEN cycles.
// Strobe is combinational on the accepting cycle (FILT_LEN+2 edges after the raw sample); no backpressure.
module hall_glitch_filter #(
    parameter int W        = 3,
    parameter int FILT_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         acc_stb
);

    localparam int FW = $clog2(FILT_LEN);
    localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);

    logic [W-1:0]  s1;
    logic [W-1:0]  sync;
    logic [W-1:0]  cand;
    logic [W-1:0]  acc_q;
    logic [FW-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            sync  <= '0;
            cand  <= '0;
            fcnt  <= '0;
            acc_q <= '0;
        end else begin
            s1   <= din;
            sync <= s1;
            if (sync != cand) begin
                cand <= sync;
                fcnt <= '0;
            end else if (fcnt != FMAX) begin
                fcnt <= fcnt + 1'b1;
            end
            if (acc_stb) begin
                acc_q <= cand;
            end
        end
    end

    // Comparing against the last accepted code makes a held code strobe only once.
    assign acc_stb = (fcnt == FMAX) && (cand != acc_q);
    assign acc     = acc_stb ? cand : acc_q;

endmodule

// File: rtl/hall_conditioner.sv
// Hall conditioning: filtered code, step/direction, step errors, period measurement, fault flags.
// Outputs register on the accept edge (FILT_LEN+3 cycles after a raw edge); no backpressure.
module hall_conditioner
    import bldc_hall_pkg::*;
#(
    parameter int FILT_LEN = 16,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       hall_raw,
    input  logic             clr_fault,
    output logic             hall_a,
    output logic             hall_b,
    output logic             hall_c,
    output logic             hall_valid,
    output logic             step,
    output logic             dir,
    output logic             step_err,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic             hall_fault,
    output logic             fault_sticky
);

    localparam logic [CNT_W-1:0] PMAX = '1;

    logic [2:0]       code;
    logic             code_stb;
    logic [2:0]       hall;
    logic             first_done;
    logic [CNT_W-1:0] pcnt;
    logic             code_ok;
    logic             is_fwd;
    logic             is_rev;

    hall_glitch_filter #(
        .W        (3),
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk     (clk),
        .rst     (rst),
        .din     (hall_raw),
        .acc     (code),
        .acc_stb (code_stb)
    );

    always_comb begin
        code_ok = is_valid(code);
        is_fwd  = (code == next_fwd(hall));
        is_rev  = (code == next_rev(hall));
    end

    assign {hall_a, hall_b, hall_c} = hall;
    assign stalled = (pcnt == PMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            hall         <= '0;
            hall_valid   <= 1'b0;
            step         <= 1'b0;
            dir          <= 1'b1;
            step_err     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            hall_fault   <= 1'b0;
            fault_sticky <= 1'b0;
            first_done   <= 1'b0;
            pcnt         <= '0;
        end else begin
            step         <= 1'b0;
            step_err     <= 1'b0;
            period_valid <= 1'b0;
            hall_fault   <= 1'b0;
            if (hall_valid && pcnt != PMAX) begin
                pcnt <= pcnt + 1'b1;
            end
            if (clr_fault) begin
                fault_sticky <= 1'b0;
            end
            if (code_stb) begin
                if (!code_ok) begin
                    hall_fault   <= 1'b1;
                    fault_sticky <= 1'b1;
                end else if (!hall_valid) begin
                    hall       <= code;
                    hall_valid <= 1'b1;
                    pcnt       <= '0;
                    first_done <= 1'b0;
                end else if (is_fwd || is_rev) begin
                    hall         <= code;
                    step         <= 1'b1;
                    dir          <= is_fwd;
                    period       <= (pcnt == PMAX) ? PMAX : pcnt + 1'b1;
                    // The interval since init or a step error is partial, so it is not published.
                    period_valid <= first_done;
                    first_done   <= 1'b1;
                    pcnt         <= '0;
                end else begin
                    hall       <= code;
                    step_err   <= 1'b1;
                    pcnt       <= '0;
                    first_done <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hall_conditioner.sv
// Bench for hall_conditioner: directed scenarios plus randomized Hall streams checked
// every cycle against a sample-history reference model.
module tb_hall_conditioner;

    localparam int F    = 4;
    localparam int CW   = 8;
    localparam int PMAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_fault = 1'b0;
    logic [2:0]    hall_raw = 3'b000;
    logic          hall_a, hall_b, hall_c, hall_valid, step, dir, step_err;
    logic [CW-1:0] period;
    logic          period_valid, stalled, hall_fault, fault_sticky;

    hall_conditioner #(.FILT_LEN(F), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_raw     (hall_raw),
        .clr_fault    (clr_fault),
        .hall_a       (hall_a),
        .hall_b       (hall_b),
        .hall_c       (hall_c),
        .hall_valid   (hall_valid),
        .step         (step),
        .dir          (dir),
        .step_err     (step_err),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .hall_fault   (hall_fault),
        .fault_sticky (fault_sticky)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    function automatic int pos(input logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (seq[i] == c) return i;
        end
        return -1;
    endfunction

    // Reference model state: raw sample history, then the spec-level classification.
    logic [2:0] d1, d2, run_val, m_acc, m_hall;
    int         run_len, m_period, m_pcnt;
    bit         m_valid, m_dir, m_step, m_err, m_pv, m_fault, m_fs, m_first, started;
    int         step_seen = 0, err_seen = 0, fault_seen = 0, pv_seen = 0, first_pv_period = -1;

    always @(posedge clk) begin
        logic [2:0] seen;
        logic [2:0] code;
        bit         accept;
        int         np, pi, pn;
        if (rst) begin
            d1 = 0; d2 = 0; run_val = 0; run_len = 1; m_acc = 0; m_hall = 0;
            m_valid = 0; m_dir = 1; m_step = 0; m_err = 0; m_pv = 0; m_fault = 0;
            m_fs = 0; m_first = 0; m_period = 0; m_pcnt = 0;
            started = 1;
        end else begin
            accept = (run_len >= F) && (run_val != m_acc);
            code   = run_val;
            seen = d2; d2 = d1; d1 = hall_raw;
            if (seen == run_val) begin
                if (run_len < F) run_len++;
            end else begin
                run_val = seen;
                run_len = 1;
            end
            m_step = 0; m_err = 0; m_pv = 0; m_fault = 0;
            np = m_valid ? ((m_pcnt < PMAX) ? m_pcnt + 1 : PMAX) : 0;
            if (accept) begin
                m_acc = code;
                if (code == 3'b000 || code == 3'b111) begin
                    m_fault = 1;
                    m_fs    = 1;
                end else if (!m_valid) begin
                    m_hall = code; m_valid = 1; np = 0; m_first = 0;
                end else begin
                    pi = pos(m_hall);
                    pn = pos(code);
                    if (pn == (pi + 1) % 6 || pi == (pn + 1) % 6) begin
                        m_step = 1;
                        m_dir = (pn == (pi + 1) % 6);
                        m_period = (m_pcnt < PMAX) ? m_pcnt + 1 : PMAX;
                        m_pv = m_first;
                        m_first = 1;
                        np = 0;
                        m_hall = code;
                    end else begin
                        m_err = 1; m_hall = code; np = 0; m_first = 0;
                    end
                end
            end
            if (clr_fault && !m_fault) m_fs = 0;
            m_pcnt = np;
        end
        if (started) begin
            #1;
            check("abc",          32'({hall_a, hall_b, hall_c}), 32'(m_hall));
            check("hall_valid",   32'(hall_valid),   32'(m_valid));
            check("step",         32'(step),         32'(m_step));
            check("dir",          32'(dir),          32'(m_dir));
            check("step_err",     32'(step_err),     32'(m_err));
            check("period",       32'(period),       32'(m_period));
            check("period_valid", 32'(period_valid), 32'(m_pv));
            check("stalled",      32'(stalled),      32'(m_valid && m_pcnt == PMAX));
            check("hall_fault",   32'(hall_fault),   32'(m_fault));
            check("fault_sticky", 32'(fault_sticky), 32'(m_fs));
            if (step) step_seen++;
            if (step_err) err_seen++;
            if (hall_fault) fault_seen++;
            if (period_valid) begin
                if (pv_seen == 0) first_pv_period = int'(period);
                pv_seen++;
            end
        end
    end

    task automatic hold(input logic [2:0] c, input int n);
        hall_raw = c;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0, p;
        repeat (3) @(negedge clk);
        check("rst_valid",  32'(hall_valid),   0);
        check("rst_dir",    32'(dir),          1);
        check("rst_period", 32'(period),       0);
        check("rst_fs",     32'(fault_sticky), 0);

        rst = 1'b0;
        hall_raw = 3'b101;
        repeat (6) @(posedge clk);
        #1 check("init_early", 32'(hall_valid), 0);
        @(posedge clk);
        #1 check("init_valid", 32'(hall_valid), 1);
        check("init_code", 32'({hall_a, hall_b, hall_c}), 32'b101);
        check("init_nostep", 32'(step_seen), 0);
        check("init_nofault", 32'(fault_seen), 0);
        @(negedge clk);
        hold(3'b101, 33);

        hold(3'b100, 40);
        hold(3'b110, 40);
        check("fwd_steps", 32'(step_seen), 2);
        check("fwd_dir", 32'(dir), 1);
        check("fwd_pv_count", 32'(pv_seen), 1);
        check("fwd_period", 32'(first_pv_period), 40);

        hold(3'b100, 20);
        hold(3'b000, 3);
        hold(3'b100, 20);
        check("glitch_nofault", 32'(fault_seen), 0);
        check("glitch_code", 32'({hall_a, hall_b, hall_c}), 32'b100);

        hold(3'b000, 10);
        check("fault_once", 32'(fault_seen), 1);
        check("fault_sticky", 32'(fault_sticky), 1);
        check("fault_hold", 32'({hall_a, hall_b, hall_c}), 32'b100);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        check("fault_clr", 32'(fault_sticky), 0);
        hall_raw = 3'b111;
        repeat (6) @(negedge clk);
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        check("fault_second", 32'(fault_seen), 2);
        check("fault_set_wins", 32'(fault_sticky), 1);
        hold(3'b111, 10);

        hold(3'b110, 40);
        s0 = step_seen;
        hold(3'b100, 40);
        check("rev_dir1", 32'(dir), 0);
        hold(3'b101, 40);
        check("rev_dir2", 32'(dir), 0);
        check("rev_steps", 32'(step_seen), 32'(s0 + 2));
        hold(3'b110, 40);
        check("skip_err", 32'(err_seen), 1);
        check("skip_nostep", 32'(step_seen), 32'(s0 + 2));

        hold(3'b110, 300);
        check("stall_on", 32'(stalled), 1);
        hold(3'b010, 20);
        check("stall_period", 32'(period), 255);
        check("stall_off", 32'(stalled), 0);
        hold(3'b011, 10);

        rst = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_valid", 32'(hall_valid), 0);
        check("mid_rst_abc", 32'({hall_a, hall_b, hall_c}), 0);
        check("mid_rst_dir", 32'(dir), 1);
        check("mid_rst_period", 32'(period), 0);
        check("mid_rst_fs", 32'(fault_sticky), 0);
        @(negedge clk);
        rst = 1'b0;

        p = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       hall_raw = 3'($urandom_range(0, 7));
                1, 2, 3: begin p = (p + 1) % 6; hall_raw = seq[p]; end
                4, 5:    begin p = (p + 5) % 6; hall_raw = seq[p]; end
                default: hall_raw = seq[p];
            endcase
            clr_fault = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) repeat (270) @(negedge clk);
            else repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        rst = 1'b0;
        clr_fault = 1'b0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
